// File: rtl/dac_pkg.sv
// Shared constants and mode encoding for the I2S stream DAC.
// Slot and volume widths are fixed by the I2S frame format and volume scaling.
package dac_pkg;

    localparam int SLOT_W = 32;
    localparam int VOL_W  = 8;

    typedef enum logic {
        MODE_I2S = 1'b0,
        MODE_LJ  = 1'b1
    } dac_mode_e;

    // One volume LSB toward the target; holds once the target is reached.
    function automatic logic [VOL_W-1:0] vol_step(input logic [VOL_W-1:0] cur,
                                                  input logic [VOL_W-1:0] tgt);
        if (cur < tgt) return cur + VOL_W'(1);
        if (cur > tgt) return cur - VOL_W'(1);
        return cur;
    endfunction

endpackage

// File: rtl/pcm_fifo.sv
// Synchronous FIFO of stereo PCM pairs with an occupancy output.
// The read data is the head entry (show-ahead), consumed by rd_en.
module pcm_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clkin,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign level   = wr_ptr - rd_ptr;

endmodule

// File: rtl/i2s_stream_dac.sv
// Streaming I2S / left-justified transmitter with a stereo-pair FIFO,
// per-channel ramped volume scaling and a sticky underrun flag.
module i2s_stream_dac
    import dac_pkg::*;
#(
    parameter int SAMPLE_W    = 16,
    parameter int DIV_LOG2    = 3,
    parameter int FIFO_DEPTH  = 16,
    parameter int RAMP_FRAMES = 4
) (
    input  logic                          clkin,
    input  logic                          nreset,
    input  logic                          enable,
    input  logic                          lj_mode,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    input  logic [VOL_W-1:0]              vol_l,
    input  logic [VOL_W-1:0]              vol_r,
    input  logic                          clr_status,
    output logic                          mclk,
    output logic                          bclk,
    output logic                          lrck,
    output logic                          sdout,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int CNT_W = DIV_LOG2 + 7;
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PAD_W = SLOT_W - SAMPLE_W;
    localparam int RC_W  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

    // Assert asynchronously, release two clkin edges after nreset rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clkin or negedge nreset) begin
        if (!nreset) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [CNT_W-1:0] cnt;
    logic             frame_edge;
    logic             bit_edge;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt + CNT_W'(1);
    end

    assign frame_edge = &cnt;
    assign bit_edge   = &cnt[DIV_LOG2:0];
    assign mclk       = cnt[DIV_LOG2-2];
    assign bclk       = cnt[DIV_LOG2];
    assign lrck       = cnt[CNT_W-1];

    logic [2*SAMPLE_W-1:0] pair_out;
    logic                  fifo_empty;
    logic                  pop;
    logic                  push;

    assign fifo_empty = (fifo_level == '0);
    assign s_ready    = rst_n && (fifo_level < LVL_W'(FIFO_DEPTH));
    assign push       = s_valid && s_ready;
    assign pop        = frame_edge && enable && !fifo_empty;

    pcm_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkin   (clkin),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({s_left, s_right}),
        .rd_en   (pop),
        .rd_data (pair_out),
        .level   (fifo_level)
    );

    logic [RC_W-1:0] ramp_cnt;
    logic            ramp_step;

    assign ramp_step = frame_edge && (ramp_cnt == RC_W'(RAMP_FRAMES-1));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)          ramp_cnt <= '0;
        else if (ramp_step)  ramp_cnt <= '0;
        else if (frame_edge) ramp_cnt <= ramp_cnt + RC_W'(1);
    end

    logic [1:0][VOL_W-1:0]  vol_tgt;
    logic [1:0][VOL_W-1:0]  cur_vol;
    logic [1:0][SLOT_W-1:0] slot;

    assign vol_tgt = {vol_r, vol_l};

    // Channel 0 = left (upper half of the FIFO word), channel 1 = right.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic signed [SAMPLE_W+8:0] samp_x;
        logic signed [SAMPLE_W+8:0] vol_x;
        logic signed [SAMPLE_W+8:0] prod;
        logic        [SAMPLE_W-1:0] samp;

        assign samp   = pair_out[(2-ch)*SAMPLE_W-1 -: SAMPLE_W];
        assign samp_x = {{9{samp[SAMPLE_W-1]}}, samp};
        assign vol_x  = {{(SAMPLE_W+1){1'b0}}, cur_vol[ch]};
        assign prod   = samp_x * vol_x;

        // Scaling uses the volume held before this edge's ramp step.
        always_ff @(posedge clkin or negedge rst_n) begin
            if (!rst_n)         cur_vol[ch] <= '0;
            else if (ramp_step) cur_vol[ch] <= vol_step(cur_vol[ch], vol_tgt[ch]);
        end

        assign slot[ch] = pop ? {SAMPLE_W'(prod >>> 8), {PAD_W{1'b0}}} : '0;
    end

    logic [2*SLOT_W-1:0] lj_word;
    logic [2*SLOT_W-1:0] frame_word;
    logic [2*SLOT_W-1:0] sreg;

    always_comb begin
        lj_word    = {slot[0], slot[1]};
        frame_word = (dac_mode_e'(lj_mode) == MODE_LJ) ? lj_word : (lj_word >> 1);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= '0;
            sdout <= 1'b0;
        end else if (frame_edge) begin
            sdout <= frame_word[2*SLOT_W-1];
            sreg  <= {frame_word[2*SLOT_W-2:0], 1'b0};
        end else if (bit_edge) begin
            sdout <= sreg[2*SLOT_W-1];
            sreg  <= {sreg[2*SLOT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n)                                    underrun <= 1'b0;
        else if (frame_edge && enable && fifo_empty)   underrun <= 1'b1;
        else if (clr_status)                           underrun <= 1'b0;
    end

endmodule

// File: tb/tb_i2s_stream_dac.sv
// Directed bench for i2s_stream_dac: reset, FIFO fill, volume ramp,
// LJ/I2S slot formatting, mid-frame reset and underrun handling.
module tb_i2s_stream_dac;

    localparam int SAMPLE_W    = 16;
    localparam int DIV_LOG2    = 3;
    localparam int FIFO_DEPTH  = 16;
    localparam int RAMP_FRAMES = 4;
    localparam int P           = 1 << (DIV_LOG2 + 1);
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

    logic                clkin;
    logic                nreset;
    logic                enable;
    logic                lj_mode;
    logic                s_valid;
    logic                s_ready;
    logic [SAMPLE_W-1:0] s_left;
    logic [SAMPLE_W-1:0] s_right;
    logic [7:0]          vol_l;
    logic [7:0]          vol_r;
    logic                clr_status;
    logic                mclk;
    logic                bclk;
    logic                lrck;
    logic                sdout;
    logic [LVL_W-1:0]    fifo_level;
    logic                underrun;

    i2s_stream_dac #(
        .SAMPLE_W    (SAMPLE_W),
        .DIV_LOG2    (DIV_LOG2),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .RAMP_FRAMES (RAMP_FRAMES)
    ) dut (
        .clkin      (clkin),
        .nreset     (nreset),
        .enable     (enable),
        .lj_mode    (lj_mode),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_left     (s_left),
        .s_right    (s_right),
        .vol_l      (vol_l),
        .vol_r      (vol_r),
        .clr_status (clr_status),
        .mclk       (mclk),
        .bclk       (bclk),
        .lrck       (lrck),
        .sdout      (sdout),
        .fifo_level (fifo_level),
        .underrun   (underrun)
    );

    initial clkin = 1'b0;
    always #5 clkin = ~clkin;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    logic [15:0] tl [16];
    logic [15:0] tr [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns on the clkin negedge just after lrck falls (a frame edge).
    task automatic wait_lrck_fall();
        logic prev;
        logic found;
        prev  = lrck;
        found = 1'b0;
        for (int i = 0; i < 2200 && !found; i++) begin
            @(negedge clkin);
            if (prev && !lrck) found = 1'b1;
            prev = lrck;
        end
        edge_n++;
        check("lrck_fall_seen", 64'(found), 64'd1);
    endtask

    // Samples all 64 bit periods of the frame that starts at the next frame edge.
    task automatic capture_frame(output logic [63:0] f);
        f = '0;
        wait_lrck_fall();
        repeat (P/2) @(negedge clkin);
        f[63] = sdout;
        for (int k = 1; k < 64; k++) begin
            repeat (P) @(negedge clkin);
            f[63-k] = sdout;
        end
    endtask

    initial begin
        logic [63:0] f;
        logic [63:0] exp_f;
        int          n;

        for (int i = 0; i < 16; i++) begin
            tl[i] = 16'h7FFF;
            tr[i] = 16'h8000;
        end
        tl[5] = 16'hA5A5; tr[5] = 16'h0000;
        tl[6] = 16'hA5A5; tr[6] = 16'h1234;

        nreset = 1'b0; enable = 1'b0; lj_mode = 1'b1; s_valid = 1'b0;
        s_left = '0; s_right = '0; vol_l = 8'd8; vol_r = 8'd8; clr_status = 1'b0;

        repeat (3) @(negedge clkin);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_sdout", 64'(sdout), 64'd0);
        check("rst_pins", 64'({mclk, bclk, lrck}), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);

        nreset = 1'b1;
        repeat (3) @(negedge clkin);
        check("rel_s_ready", 64'(s_ready), 64'd1);
        check("rel_lrck", 64'(lrck), 64'd0);

        // Fill the FIFO while disabled; the 17th offer must be refused.
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1; s_left = tl[i]; s_right = tr[i];
            @(negedge clkin);
        end
        s_valid = 1'b0;
        check("full_level", 64'(fifo_level), 64'd16);
        check("full_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b1; s_left = 16'h1111; s_right = 16'h2222;
        @(negedge clkin);
        s_valid = 1'b0;
        check("push17_level", 64'(fifo_level), 64'd16);

        capture_frame(f);
        check("disabled_frame", f, 64'd0);
        check("disabled_no_pop", 64'(fifo_level), 64'd16);
        check("disabled_no_underrun", 64'(underrun), 64'd0);

        while (edge_n < 29) wait_lrck_fall();
        enable = 1'b1;

        // Edges 30..32 scale with volume 7, edges 33.. with the target 8.
        for (int e = 30; e <= 34; e++) begin
            capture_frame(f);
            if (e < 33) exp_f = {16'h037F, 16'h0000, 16'hFC80, 16'h0000};
            else        exp_f = {16'h03FF, 16'h0000, 16'hFC00, 16'h0000};
            check($sformatf("lj_ramp_frame%0d", e), f, exp_f);
        end
        check("level_after_5_pops", 64'(fifo_level), 64'd11);

        lj_mode = 1'b0;
        wait_lrck_fall();
        n = 0;
        do begin
            @(negedge clkin);
            n++;
        end while (!sdout && n < 4*P);
        check("i2s_msb_delay", 64'(n), 64'(P));

        capture_frame(f);
        check("i2s_frame", f, {1'b0, 16'hFD2D, 16'h0000, 16'h0091, 15'h0000});
        check("level_after_7_pops", 64'(fifo_level), 64'd9);

        lj_mode = 1'b1;
        wait_lrck_fall();
        repeat (8*P + P/2) @(negedge clkin);
        check("pre_reset_level", 64'(fifo_level), 64'd8);
        check("pre_reset_sdout", 64'(sdout), 64'd1);
        nreset = 1'b0;
        #1;
        check("midrst_sdout", 64'(sdout), 64'd0);
        check("midrst_level", 64'(fifo_level), 64'd0);
        check("midrst_s_ready", 64'(s_ready), 64'd0);
        check("midrst_clocks", 64'({bclk, lrck}), 64'd0);

        repeat (2) @(negedge clkin);
        nreset = 1'b1;
        repeat (3) @(negedge clkin);
        check("restart_s_ready", 64'(s_ready), 64'd1);
        check("restart_lrck", 64'(lrck), 64'd0);
        check("restart_level", 64'(fifo_level), 64'd0);
        check("restart_underrun", 64'(underrun), 64'd0);

        capture_frame(f);
        check("underrun_frame", f, 64'd0);
        check("underrun_set", 64'(underrun), 64'd1);
        clr_status = 1'b1;
        @(negedge clkin);
        clr_status = 1'b0;
        @(negedge clkin);
        check("underrun_cleared", 64'(underrun), 64'd0);

        // Clear held across an underrun edge: the set takes priority.
        clr_status = 1'b1;
        wait_lrck_fall();
        check("set_over_clr", 64'(underrun), 64'd1);
        @(negedge clkin);
        check("clr_after_set", 64'(underrun), 64'd0);
        clr_status = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2s_stream_dac.md
I2S_STREAM_DAC -- requirements
Module: i2s_stream_dac

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, PCM sample width, legal 16..24.
REQ-002 SHALL have parameter DIV_LOG2, default 3, where bclk period = 2^(DIV_LOG2+1) clkin cycles; legal >=2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, stereo-pair FIFO depth; power of 2, >=2.
REQ-004 SHALL have parameter RAMP_FRAMES, default 4, frames per 1-LSB volume step; >=1.
REQ-005 SHALL have port clkin, input, 1, sole clock.
REQ-006 SHALL have port nreset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1; 0 = output silence, no FIFO pops.
REQ-008 SHALL have port lj_mode, input, 1; 1 = left-justified, 0 = I2S (1-bclk MSB delay).
REQ-009 SHALL have ports s_valid/s_ready, input/output, 1 each, sample write handshake.
REQ-010 SHALL have ports s_left/s_right, input, SAMPLE_W each, signed two's-complement PCM.
REQ-011 SHALL have ports vol_l/vol_r, input, 8 each, target volume; 255 = ~unity.
REQ-012 SHALL have port clr_status, input, 1, clears underrun.
REQ-013 SHALL have ports mclk, bclk, lrck, sdout, output, 1 each; I2S pins.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, occupied entries.
REQ-015 SHALL have port underrun, output, 1, sticky flag.

Function
REQ-016 SHALL run free counter cnt, width DIV_LOG2+7, +1 per clkin, wrapping; mclk=cnt[DIV_LOG2-2], bclk=cnt[DIV_LOG2], lrck=cnt[MSB] (0 = left); 32 bclk per slot, 256 mclk per frame.
REQ-017 SHALL accept a pair when s_valid&&s_ready; s_ready = (fifo_level<FIFO_DEPTH), registered-state-derived only.
REQ-018 SHALL define frame edge as the clkin edge where cnt==all-ones.
REQ-019 At frame edge with enable=1 and FIFO non-empty: SHALL pop one pair and load both channel shift registers with scaled samples.
REQ-020 At frame edge with enable=1 and FIFO empty: SHALL load zeros and set underrun; no pop.
REQ-021 At frame edge with enable=0: SHALL load zeros, no pop, no underrun.
REQ-022 Simultaneous push and pop SHALL leave fifo_level unchanged; push while full is impossible (s_ready=0).
REQ-023 Scaling: out = (sample * cur_vol) arithmetic-shift-right 8, cur_vol unsigned 8-bit, result SAMPLE_W, no saturation needed.
REQ-024 cur_vol_l/r SHALL move 1 LSB toward target every RAMP_FRAMES frame edges, evaluated at frame edge before scaling is applied next frame; equal = hold.
REQ-025 sdout SHALL be registered, updated only on clkin edges where bclk goes 1->0 (and at cnt wrap).
REQ-026 Each 32-bit slot SHALL carry sample MSB-first, SAMPLE_W bits, remaining bits 0.
REQ-027 lj_mode=1: MSB on the bclk falling edge coinciding with lrck transition; lj_mode=0: MSB one bclk later, LSB of previous slot's tail bit is 0.
REQ-028 lj_mode/enable changes SHALL take effect at next frame edge only (sampled there).
REQ-029 underrun SHALL stay 1 until clr_status=1 sampled; set wins over simultaneous clear.

Reset
REQ-030 nreset low SHALL asynchronously force cnt=0, FIFO empty, fifo_level=0, s_ready=0 during reset then 1, shift regs=0, sdout=0, cur_vol=0, underrun=0, mclk/bclk/lrck=0.
REQ-031 Reset mid-frame SHALL discard FIFO contents; first frame after release outputs zeros (starts at cnt=0).
REQ-032 nreset deassertion SHALL be synchronised to clkin (2-flop) before release.

Structure
REQ-033 SHALL place slot width (32), volume width (8) and mode encodings in shared package dac_pkg.
REQ-034 SHALL instantiate sub-module pcm_fifo (SAMPLE_W*2 wide, FIFO_DEPTH deep, synchronous, level output).
REQ-035 Volume ramp and scaling SHALL be per-channel identical logic (generate loop over 2 channels).

Verification
REQ-036 Defaults, vol targets 255 after ramp, push L=16'h7FFF,R=16'h8000, lj_mode=1 -> left slot bits 7F7F..., right 16'h8080 then 16 zeros.
REQ-037 lj_mode=0, L=16'hA5A5 -> sdout MSB appears exactly 2^(DIV_LOG2+1) clkin after lrck falls.
REQ-038 FIFO empty at frame edge, enable=1 -> slots all zero, underrun=1; clr_status pulse -> 0.
REQ-039 Push 17 pairs with no pops (enable=0) -> s_ready=0 after 16, fifo_level=16, 17th not accepted.
REQ-040 cur_vol 0, target 8, RAMP_FRAMES=4 -> volume reaches 8 after 32 frame edges, monotonic.
REQ-041 nreset asserted mid-slot with 5 queued -> sdout=0, fifo_level=0 immediately; restart lrck=0 from cnt=0.
